// File: rtl/pwm_cfg_sequencer_if.sv
// Write-port bundle for pwm_cfg_sequencer: valid/ready handshake plus the
// target carrier, register select and data of one shadow-register write.
interface pwm_cfg_sequencer_if #(
  parameter int CNT_W = 16,
  parameter int CH_W  = 3
);
  logic             wr_valid;
  logic             wr_ready;
  logic [CH_W-1:0]  wr_chan;
  logic [1:0]       wr_reg;
  logic [CNT_W-1:0] wr_data;

  modport master (output wr_valid, wr_chan, wr_reg, wr_data, input wr_ready);
  modport slave  (input wr_valid, wr_chan, wr_reg, wr_data, output wr_ready);
endinterface

// File: rtl/pwm_cfg_sequencer.sv
// Shadow-register update sequencer for the 8-carrier PWM core.
// Writes land in per-carrier shadow registers; an arm request moves dirty
// carriers to ARMED, and each ARMED carrier copies its whole shadow set to the
// active buses on its selected boundary event, so the core never sees a
// half-updated carrier.
// Optional build macro PWMCFGSEQ_TIMEOUT_EN adds a per-carrier wait counter
// that force-commits after TMO_CYC ARMED cycles and raises a sticky tmo_flag.
module pwm_cfg_sequencer #(
  parameter int N_CARR  = 8,
  parameter int CNT_W   = 16
`ifdef PWMCFGSEQ_TIMEOUT_EN
  ,
  parameter int TMO_CYC = 65535
`endif
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      pwm_onoff,
  pwm_cfg_sequencer_if.slave        wr_if,
  input  logic                      arm_strobe,
  input  logic [N_CARR-1:0]         arm_mask,
  input  logic [1:0]                upd_mode,
  input  logic [N_CARR-1:0]         carr_zero_x,
  input  logic [N_CARR-1:0]         carr_peak_x,
  output logic [CNT_W*N_CARR-1:0]   period_x,
  output logic [CNT_W*N_CARR-1:0]   compare_x,
  output logic [CNT_W*N_CARR-1:0]   initcarr_x,
  output logic [2*N_CARR-1:0]       countmode_x,
  output logic [N_CARR-1:0]         pending_x,
  output logic [N_CARR-1:0]         upd_done_x,
  output logic                      tmo_flag
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ARMED = 1'b1;
  localparam int         CH_W  = $clog2(N_CARR);

  logic [0:0]        state_q    [N_CARR];
  logic [0:0]        state_d    [N_CARR];
  logic [CNT_W-1:0]  sh_per_q   [N_CARR];
  logic [CNT_W-1:0]  sh_cmp_q   [N_CARR];
  logic [CNT_W-1:0]  sh_init_q  [N_CARR];
  logic [1:0]        sh_mode_q  [N_CARR];
  logic [CNT_W-1:0]  act_per_q  [N_CARR];
  logic [CNT_W-1:0]  act_cmp_q  [N_CARR];
  logic [CNT_W-1:0]  act_init_q [N_CARR];
  logic [1:0]        act_mode_q [N_CARR];
  logic [N_CARR-1:0] dirty_q, dirty_d;
  logic [N_CARR-1:0] done_q, done_d;
  logic [N_CARR-1:0] armed, wr_hit, ev_hit, commit, arm_go, tmo_hit;
  logic              wr_acc;

  // A carrier that is waiting to commit must not have its shadow set disturbed.
  assign wr_if.wr_ready = (state_q[wr_if.wr_chan] == IDLE);

  // Per-carrier decode: write hit, boundary event, commit and arm decisions.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    wr_acc  = wr_if.wr_valid & wr_if.wr_ready;
    armed   = '0;
    wr_hit  = '0;
    ev_hit  = '0;
    commit  = '0;
    arm_go  = '0;
    for (int i = 0; i < N_CARR; i++) begin
      state_d[i] = state_q[i];
      armed[i]   = (state_q[i] == ARMED);
      wr_hit[i]  = wr_acc && (wr_if.wr_chan == CH_W'(i));
      unique case (upd_mode)
        2'd0:    ev_hit[i] = 1'b1;
        2'd1:    ev_hit[i] = carr_zero_x[i];
        2'd2:    ev_hit[i] = carr_peak_x[i];
        default: ev_hit[i] = carr_zero_x[i] | carr_peak_x[i];
      endcase
      // Only events seen while already ARMED count; a stopped core always commits.
      commit[i] = armed[i] & (ev_hit[i] | ~pwm_onoff | tmo_hit[i]);
      // A write accepted in the arm cycle makes the carrier eligible.
      arm_go[i] = arm_strobe & arm_mask[i] & ~armed[i] & (dirty_q[i] | wr_hit[i]);
      if (commit[i])      state_d[i] = IDLE;
      else if (arm_go[i]) state_d[i] = ARMED;
    end
    dirty_d = (dirty_q | wr_hit) & ~commit;
    done_d  = commit;
  end

  // Shadow registers capture accepted writes; countmode keeps only two bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the shadow arrays are reset too, because an arm after reset must
      // commit a defined configuration even for fields that were never written.
      for (int i = 0; i < N_CARR; i++) begin
        sh_per_q[i]  <= '0;
        sh_cmp_q[i]  <= '0;
        sh_init_q[i] <= '0;
        sh_mode_q[i] <= '0;
      end
      dirty_q <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      dirty_q <= dirty_d;
      for (int i = 0; i < N_CARR; i++) begin
        if (wr_hit[i]) begin
          unique case (wr_if.wr_reg)
            2'd0:    sh_per_q[i]  <= wr_if.wr_data;
            2'd1:    sh_cmp_q[i]  <= wr_if.wr_data;
            2'd2:    sh_init_q[i] <= wr_if.wr_data;
            default: sh_mode_q[i] <= wr_if.wr_data[1:0];
          endcase
        end
      end
    end
  end

  // Carrier FSMs and atomic shadow-to-active transfer with compare clamp.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_CARR; i++) begin
        state_q[i]    <= IDLE;
        act_per_q[i]  <= '0;
        act_cmp_q[i]  <= '0;
        act_init_q[i] <= '0;
        act_mode_q[i] <= '0;
      end
      done_q <= '0;
    end else begin
      done_q <= done_d;
      for (int i = 0; i < N_CARR; i++) begin
        state_q[i] <= state_d[i];
        if (commit[i]) begin
          act_per_q[i]  <= sh_per_q[i];
          act_cmp_q[i]  <= (sh_cmp_q[i] > sh_per_q[i]) ? sh_per_q[i] : sh_cmp_q[i];
          act_init_q[i] <= sh_init_q[i];
          act_mode_q[i] <= sh_mode_q[i];
        end
      end
    end
  end

`ifdef PWMCFGSEQ_TIMEOUT_EN
  localparam int TMO_W = $clog2(TMO_CYC + 1);

  logic [TMO_W-1:0] wait_q [N_CARR];
  logic             tmo_flag_q;

  // A carrier that has waited TMO_CYC ARMED cycles commits on the next edge.
  always_comb begin
    tmo_hit = '0;
    for (int i = 0; i < N_CARR; i++) begin
      tmo_hit[i] = (state_q[i] == ARMED) && (wait_q[i] == TMO_W'(TMO_CYC));
    end
  end

  // Wait counters restart on arming and advance on every ARMED cycle; flag is sticky.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_CARR; i++) wait_q[i] <= '0;
      tmo_flag_q <= 1'b0;
    end else begin
      for (int i = 0; i < N_CARR; i++) begin
        if (arm_go[i])                  wait_q[i] <= '0;
        else if (armed[i] && !commit[i]) wait_q[i] <= wait_q[i] + 1'b1;
      end
      if (|tmo_hit) tmo_flag_q <= 1'b1;
    end
  end

  assign tmo_flag = tmo_flag_q;
`else
  assign tmo_hit  = '0;
  assign tmo_flag = 1'b0;
`endif

  // Pack the active registers onto the core-facing buses, carrier 0 at the LSBs.
  always_comb begin
    period_x    = '0;
    compare_x   = '0;
    initcarr_x  = '0;
    countmode_x = '0;
    for (int i = 0; i < N_CARR; i++) begin
      period_x[i*CNT_W +: CNT_W]   = act_per_q[i];
      compare_x[i*CNT_W +: CNT_W]  = act_cmp_q[i];
      initcarr_x[i*CNT_W +: CNT_W] = act_init_q[i];
      countmode_x[2*i +: 2]        = act_mode_q[i];
    end
  end

  assign pending_x  = armed;
  assign upd_done_x = done_q;

endmodule

// File: tb/tb_pwm_cfg_sequencer.sv
// Self-checking bench for pwm_cfg_sequencer: a behavioural model of the
// shadow/arm/commit rules is compared with the DUT every cycle, and the
// directed scenarios pin key values with hand-computed literals.
// Build with +define+PWMCFGSEQ_TIMEOUT_EN to exercise the timeout variant.
module tb_pwm_cfg_sequencer;

  localparam int N = 8;
`ifdef PWMCFGSEQ_TIMEOUT_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif
  localparam int TMO = 100;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           pwm_onoff = 1'b1;
  logic           arm_strobe = 1'b0;
  logic [N-1:0]   arm_mask = '0;
  logic [1:0]     upd_mode = 2'd0;
  logic [N-1:0]   carr_zero_x = '0;
  logic [N-1:0]   carr_peak_x = '0;
  logic [16*N-1:0] period_x, compare_x, initcarr_x;
  logic [2*N-1:0] countmode_x;
  logic [N-1:0]   pending_x, upd_done_x;
  logic           tmo_flag;

  pwm_cfg_sequencer_if #(.CNT_W(16), .CH_W(3)) wr_if ();

  pwm_cfg_sequencer #(
    .N_CARR (N),
    .CNT_W  (16)
`ifdef PWMCFGSEQ_TIMEOUT_EN
    ,
    .TMO_CYC(TMO)
`endif
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pwm_onoff  (pwm_onoff),
    .wr_if      (wr_if),
    .arm_strobe (arm_strobe),
    .arm_mask   (arm_mask),
    .upd_mode   (upd_mode),
    .carr_zero_x(carr_zero_x),
    .carr_peak_x(carr_peak_x),
    .period_x   (period_x),
    .compare_x  (compare_x),
    .initcarr_x (initcarr_x),
    .countmode_x(countmode_x),
    .pending_x  (pending_x),
    .upd_done_x (upd_done_x),
    .tmo_flag   (tmo_flag)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  int m_per [N], m_cmp [N], m_init [N], m_mode [N];   // shadow contents
  int a_per [N], a_cmp [N], a_init [N], a_mode [N];   // active contents
  bit m_dirty [N], m_armed [N], m_done [N];
  int m_age [N];                                      // edges spent ARMED
  bit m_tmo;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        m_per[i] = 0; m_cmp[i] = 0; m_init[i] = 0; m_mode[i] = 0;
        a_per[i] = 0; a_cmp[i] = 0; a_init[i] = 0; a_mode[i] = 0;
        m_dirty[i] = 0; m_armed[i] = 0; m_done[i] = 0; m_age[i] = 0;
      end
      m_tmo = 0;
    end else begin
      bit         acc;
      bit [N-1:0] cm, go, timed_out;
      acc = wr_if.wr_valid && !m_armed[wr_if.wr_chan];
      for (int i = 0; i < N; i++) begin
        bit ev;
        ev = (upd_mode == 2'd0) || (upd_mode[0] && carr_zero_x[i]) || (upd_mode[1] && carr_peak_x[i]);
        timed_out[i] = TMO_ON && m_armed[i] && (m_age[i] == TMO);
        cm[i] = m_armed[i] && (ev || !pwm_onoff || timed_out[i]);
        go[i] = arm_strobe && arm_mask[i] && !m_armed[i] && (m_dirty[i] || (acc && wr_if.wr_chan == i));
      end
      for (int i = 0; i < N; i++) begin
        m_done[i] = cm[i];
        if (cm[i]) begin
          a_per[i]   = m_per[i];
          a_cmp[i]   = (m_cmp[i] < m_per[i]) ? m_cmp[i] : m_per[i];
          a_init[i]  = m_init[i];
          a_mode[i]  = m_mode[i];
          m_dirty[i] = 0;
          m_armed[i] = 0;
          if (timed_out[i]) m_tmo = 1;
        end
      end
      if (acc) begin
        case (wr_if.wr_reg)
          2'd0: m_per[wr_if.wr_chan]  = int'(wr_if.wr_data);
          2'd1: m_cmp[wr_if.wr_chan]  = int'(wr_if.wr_data);
          2'd2: m_init[wr_if.wr_chan] = int'(wr_if.wr_data);
          default: m_mode[wr_if.wr_chan] = int'(wr_if.wr_data[1:0]);
        endcase
        m_dirty[wr_if.wr_chan] = 1;
      end
      for (int i = 0; i < N; i++) begin
        if (go[i]) begin
          m_armed[i] = 1;
          m_age[i]   = 0;
        end else if (m_armed[i]) begin
          m_age[i]++;
        end
      end
    end
  end

  // Every cycle, compare all DUT outputs with the model on the falling edge.
  always @(negedge clk) begin
    logic [16*N-1:0] ep, ec, ei;
    logic [2*N-1:0]  em;
    logic [N-1:0]    epd, edn;
    for (int i = 0; i < N; i++) begin
      ep[i*16 +: 16] = 16'(a_per[i]);
      ec[i*16 +: 16] = 16'(a_cmp[i]);
      ei[i*16 +: 16] = 16'(a_init[i]);
      em[i*2 +: 2]   = 2'(a_mode[i]);
      epd[i]         = m_armed[i];
      edn[i]         = m_done[i];
    end
    check("model_period_x", period_x, ep);
    check("model_compare_x", compare_x, ec);
    check("model_initcarr_x", initcarr_x, ei);
    check("model_countmode_x", countmode_x, em);
    check("model_pending_x", pending_x, epd);
    check("model_upd_done_x", upd_done_x, edn);
    check("model_tmo_flag", tmo_flag, m_tmo);
    check("model_wr_ready", wr_if.wr_ready, !m_armed[wr_if.wr_chan]);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int ch, input int rg, input int data);
    bit ok, r;
    ok = 0;
    wr_if.wr_valid = 1'b1;
    wr_if.wr_chan  = 3'(ch);
    wr_if.wr_reg   = 2'(rg);
    wr_if.wr_data  = 16'(data);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      r = wr_if.wr_ready;
      @(posedge clk);
      #1;
      if (r) begin
        ok = 1;
        break;
      end
    end
    wr_if.wr_valid = 1'b0;
    if (!ok) check("write_accept_timeout", 1'b0, 1'b1);
  endtask

  task automatic do_arm(input logic [N-1:0] mask, input logic [1:0] mode);
    arm_strobe = 1'b1;
    arm_mask   = mask;
    upd_mode   = mode;
    tick();
    arm_strobe = 1'b0;
    arm_mask   = '0;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int hit_at;
    wr_if.wr_valid = 1'b0;
    wr_if.wr_chan  = '0;
    wr_if.wr_reg   = '0;
    wr_if.wr_data  = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state.
    check("rst_period", period_x, '0);
    check("rst_pending", pending_x, '0);
    check("rst_done", upd_done_x, '0);
    check("rst_tmo", tmo_flag, 1'b0);
    check("rst_ready", wr_if.wr_ready, 1'b1);

    // Carrier 0 full write, commit on zero pulse.
    do_write(0, 0, 2000);
    do_write(0, 1, 500);
    do_write(0, 2, 1500);
    do_write(0, 3, 2);
    do_arm(8'h01, 2'd1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("c0_pre_commit_period", period_x[15:0], 16'd0);
    end
    tick();
    carr_zero_x = 8'h01;
    tick();
    carr_zero_x = 8'h00;
    check("c0_period", period_x[15:0], 16'd2000);
    check("c0_compare", compare_x[15:0], 16'd500);
    check("c0_initcarr", initcarr_x[15:0], 16'd1500);
    check("c0_countmode", countmode_x[1:0], 2'd2);
    check("c0_done_pulse", upd_done_x, 8'h01);
    tick();
    check("c0_done_cleared", upd_done_x, 8'h00);

    // Write to an ARMED carrier stalls until the commit.
    do_write(0, 0, 3000);
    do_arm(8'h01, 2'd1);
    fork
      do_write(0, 1, 700);
      begin
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check("c0_stall_ready", wr_if.wr_ready, 1'b0);
        end
        tick();
        carr_zero_x = 8'h01;
        tick();
        carr_zero_x = 8'h00;
        check("c0_recommit_period", period_x[15:0], 16'd3000);
      end
    join
    check("c0_stalled_write_inactive", compare_x[15:0], 16'd500);

    // Compare clamp on carrier 3, immediate mode.
    do_write(3, 0, 1000);
    do_write(3, 1, 3000);
    do_arm(8'h08, 2'd0);
    check("c3_armed", pending_x, 8'h08);
    check("c3_not_yet", compare_x[63:48], 16'd0);
    tick();
    check("c3_clamped", compare_x[63:48], 16'd1000);
    check("c3_done", upd_done_x, 8'h08);
    do_write(3, 0, 4000);
    do_arm(8'h08, 2'd0);
    tick();
    check("c3_shadow_kept", compare_x[63:48], 16'd3000);

    // Carriers 1 and 2 on peak; write to 2 and a peak in the arm cycle itself.
    do_write(1, 0, 100);
    wr_if.wr_valid = 1'b1;
    wr_if.wr_chan  = 3'd2;
    wr_if.wr_reg   = 2'd0;
    wr_if.wr_data  = 16'd200;
    arm_strobe     = 1'b1;
    arm_mask       = 8'h06;
    upd_mode       = 2'd2;
    carr_peak_x    = 8'h06;
    tick();
    wr_if.wr_valid = 1'b0;
    arm_strobe     = 1'b0;
    arm_mask       = '0;
    carr_peak_x    = '0;
    check("c12_armed", pending_x, 8'h06);
    check("c12_no_commit_in_arm", upd_done_x, 8'h00);
    tick();
    tick();
    check("c12_still_armed", pending_x, 8'h06);
    carr_peak_x = 8'h06;
    tick();
    carr_peak_x = '0;
    check("c12_done_together", upd_done_x, 8'h06);
    check("c1_period", period_x[31:16], 16'd100);
    check("c2_period", period_x[47:32], 16'd200);
    tick();
    check("c12_done_cleared", upd_done_x, 8'h00);

    // Carrier 5 forced out by pwm_onoff = 0.
    do_write(5, 0, 50);
    do_arm(8'h20, 2'd1);
    repeat (5) tick();
    check("c5_waiting", pending_x, 8'h20);
    pwm_onoff = 1'b0;
    tick();
    pwm_onoff = 1'b1;
    check("c5_forced_done", upd_done_x, 8'h20);
    check("c5_period", period_x[95:80], 16'd50);

    // Reset while carrier 4 is ARMED.
    do_write(4, 0, 77);
    do_arm(8'h10, 2'd1);
    check("c4_armed", pending_x, 8'h10);
    reset = 1'b1;
    #1;
    check("rst_mid_pending", pending_x, 8'h00);
    check("rst_mid_period", period_x, '0);
    check("rst_mid_compare", compare_x, '0);
    check("rst_mid_ready", wr_if.wr_ready, 1'b1);
    @(posedge clk);
    #1 reset = 1'b0;

    // Carrier 7 on peak with no peaks: timeout behaviour.
    do_write(7, 0, 60);
    do_arm(8'h80, 2'd2);
    hit_at = 0;
    for (int k = 1; k <= 150; k++) begin
      tick();
      if (upd_done_x[7]) begin
        hit_at = k;
        break;
      end
    end
    if (TMO_ON) begin
      check("c7_timeout_cycle", 32'(hit_at), 32'd101);
      check("c7_tmo_flag", tmo_flag, 1'b1);
      check("c7_period", period_x[127:112], 16'd60);
      repeat (5) tick();
      check("c7_tmo_sticky", tmo_flag, 1'b1);
    end else begin
      check("c7_never_commits", 32'(hit_at), 32'd0);
      check("c7_still_armed", pending_x[7], 1'b1);
      check("c7_tmo_zero", tmo_flag, 1'b0);
    end

    tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pwm_cfg_sequencer.md
Name: pwm_cfg_sequencer

Overview:
- Shadow-register update sequencer in front of the 8-carrier 16-bit PWM core.
- Accepts per-carrier register writes over a valid/ready port and holds them in shadow registers.
- Commits each carrier's shadow set atomically to the active configuration buses on a carrier boundary event, so period, compare, initcarr and countmode never change mid-carrier.
- The active buses drive period_x, compare_x, initcarr_x and countmode_x of the PWM core directly.

Parameters:
- N_CARR, 8, number of carriers.
- CNT_W, 16, counter/register width.
- TMO_CYC, 65535, timeout cycles (optional feature only).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- pwm_onoff  in  1  PWM core enable (1 = running)
- wr_valid  in  1  write request
- wr_ready  out  1  write accepted when valid&ready
- wr_chan  in  3  target carrier index
- wr_reg  in  2  0 = period, 1 = compare, 2 = initcarr, 3 = countmode (data[1:0])
- wr_data  in  CNT_W  write data
- arm_strobe  in  1  one-cycle arm request
- arm_mask  in  N_CARR  carriers to arm on arm_strobe
- upd_mode  in  2  0 = immediate, 1 = on zero, 2 = on peak, 3 = on zero or peak
- carr_zero_x  in  N_CARR  per-carrier counter-at-zero pulse from core
- carr_peak_x  in  N_CARR  per-carrier counter-at-period pulse from core
- period_x  out  CNT_W*N_CARR  active period, packed, carrier 0 at LSBs
- compare_x  out  CNT_W*N_CARR  active compare, packed
- initcarr_x  out  CNT_W*N_CARR  active initial carrier value, packed
- countmode_x  out  2*N_CARR  active count mode, packed
- pending_x  out  N_CARR  carrier is ARMED
- upd_done_x  out  N_CARR  one-cycle pulse on commit
- tmo_flag  out  1  sticky timeout indicator

Behaviour:
- Reset (async): all active and shadow registers are 0, dirty is 0, all carriers IDLE.
  - pending_x, upd_done_x and tmo_flag are 0; wr_ready is 1.
- Each carrier runs a two-state FSM: IDLE and ARMED.
- Write path:
  - wr_ready = NOT ARMED[wr_chan]. Writes to an ARMED carrier stall.
  - An accepted write at cycle T updates the shadow register and sets dirty[chan] at T+1.
  - wr_reg = 3 stores wr_data[1:0] only.
- Arm:
  - arm_strobe at T moves every carrier with arm_mask[i] & (dirty[i] OR write accepted to i at T) from IDLE to ARMED at T+1.
  - A write accepted in the arm cycle is included in the armed set.
  - Non-dirty carriers ignore the arm.
  - Arming an already ARMED carrier has no effect.
- Commit condition, evaluated only while ARMED:
  - upd_mode 0: commits unconditionally.
  - upd_mode 1: commits when carr_zero_x[i] = 1.
  - upd_mode 2: commits when carr_peak_x[i] = 1.
  - upd_mode 3: commits on either pulse.
  - pwm_onoff = 0 forces commit regardless of mode.
- Commit timing:
  - Condition true at T: active registers load from shadow at T+1, upd_done_x[i] pulses at T+1, dirty[i] clears, FSM returns to IDLE.
  - An event in the same cycle as arm_strobe does not commit; only events seen while already ARMED count.
- Compare clamp at commit: if shadow compare > shadow period, active compare = shadow period. Shadow keeps the written value.
- Period 0 passes through unchanged; the core handles the disabled carrier.
- Simultaneous commits on several carriers are independent; all commit in the same cycle.
- Shadow registers keep their values after commit. Later writes modify them incrementally.
- upd_mode is sampled every cycle. A change while ARMED applies to subsequent cycles.
- Reset mid-ARMED: the pending update is discarded and the active values return to 0.

Optional Feature:
- Macro: PWMCFGSEQ_TIMEOUT_EN.
- With the macro:
  - Each carrier has a wait counter, cleared on entry to ARMED and incremented each ARMED cycle.
  - When the counter reaches TMO_CYC without a commit, the carrier force-commits on the next cycle, identical to a normal commit, and tmo_flag sets.
  - tmo_flag is cleared only by reset.
- Without the macro: no counters, tmo_flag is tied 0, and an ARMED carrier waits indefinitely.

Test Plan:
- After reset, write carrier 0 period = 2000, compare = 500, initcarr = 1500, mode = 2 (UPDOWN); arm mask 0x01, upd_mode 1, pwm_onoff 1; zero pulse 10 cycles later -> period_x[15:0] = 2000, compare 500, initcarr 1500 one cycle after the pulse; upd_done_x[0] pulses once; outputs stay 0 before the pulse.
- Carrier 0 ARMED, then write to carrier 0 -> wr_ready = 0 until the commit cycle; the write completes one cycle after commit; active values are unaffected by it until the next arm/commit.
- Write carrier 3 compare = 3000 with period = 1000; arm with upd_mode 0 -> compare_x[63:48] = 1000 two cycles after arm_strobe (commit condition true the cycle after arm, load on the following cycle); the shadow register still holds 3000.
- Arm carriers 1 and 2 in mode 2; peak pulse on 1 and 2 in the same cycle -> both commit together and upd_done_x = 0x06 for one cycle; peak pulse in the arm cycle itself -> no commit.
- Carrier 5 ARMED in mode 1 with no events; drop pwm_onoff -> commit on the next cycle; assert reset while carrier 4 is ARMED -> pending_x = 0 and all outputs 0 immediately.
- With PWMCFGSEQ_TIMEOUT_EN and TMO_CYC = 100: arm carrier 7 in mode 2 with no peaks -> forced commit about 101 cycles later, tmo_flag = 1 and sticky; without the macro -> carrier stays ARMED and tmo_flag = 0.
